cam_stream_gen: RTL and testbench
=================================

Name: cam_stream_gen

Overview:
- OV7670-style camera emulator: the transmitting end of the PCLK/HREF/VSYNC/8-bit pixel bus that cam_read receives.
- Generates QQVGA RGB444 frames from an internal test-pattern engine.
- Used in place of the physical camera for bring-up and in simulation, so that cam_read, buffer_ram_dp and procesamiento can be exercised deterministically.
- Single clock domain; the pixel clock is produced as a divided output.

Parameters:
- H_ACTIVE, 160, active pixels per line.
- V_ACTIVE, 120, active lines per frame.
- H_BLANK, 144, PCLK cycles with HREF low after each line's active bytes.
- VSYNC_LINES, 3, line-times with VSYNC high.
- V_BACK, 17, idle line-times between VSYNC fall and first active line.
- V_FRONT, 10, idle line-times after last active line.
- PCLK_DIV, 2, clk cycles per PCLK half-period (min 1).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset; asynchronous, active-low.
- en  in  1  enable frame generation.
- mode  in  2  pattern: 0 solid, 1 colour bars, 2 gradient, 3 checkerboard.
- solid_color  in  12  RGB444 colour for modes 0 and 3.
- CAM_pclk  out  1  generated pixel clock.
- CAM_href  out  1  line-valid.
- CAM_vsync  out  1  frame sync, active high.
- CAM_px_data  out  8  pixel byte.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-clk pulse at end of each frame.
- frame_cnt  out  16  completed frames, wraps at 0xFFFF->0.

Behaviour:
- Reset (rst=0, async): all outputs 0; divider, counters and frame_cnt 0; state IDLE.
- PCLK generation:
  - Free-running after reset: low PCLK_DIV clks, then high PCLK_DIV clks (25 MHz at defaults).
  - "tick" = the clk cycle on which CAM_pclk goes high->low.
  - HREF, VSYNC and data change only on ticks, so they are stable at the receiver's rising PCLK edge.
- Line timing: line = 2*H_ACTIVE + H_BLANK PCLK cycles (464 at defaults).
- Pixel encoding: 2 bytes per pixel.
  - Byte 0 = {4'h0, R}.
  - Byte 1 = {G, B}.
- State machine (transitions on ticks):
  - IDLE: outputs low. If en=1 at a tick, latch mode and solid_color, go to VSYNC.
  - VSYNC: CAM_vsync=1 for VSYNC_LINES*line PCLKs, then go to VBACK.
  - VBACK: all low for V_BACK lines, then go to ACTIVE.
  - ACTIVE: per line, HREF=1 for 2*H_ACTIVE PCLKs carrying the pixel bytes, then HREF=0 and data=0 for H_BLANK. After V_ACTIVE lines, go to VFRONT.
  - VFRONT: all low for V_FRONT lines. At its last tick, pulse frame_done and increment frame_cnt. Then go to VSYNC if en=1, else IDLE.
- en deasserted mid-frame: the current frame completes; no partial frames.
- busy = state != IDLE.
- Pattern mode, colour, x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1) are held constant for a whole frame.
- Pattern definitions:
  - mode 0: every pixel = solid_color.
  - mode 1: 8 bars, width H_ACTIVE/8 (20 px), left to right: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - mode 2: R = x[7:4], G = y[6:3], B = frame_cnt[3:0].
  - mode 3: solid_color where x[3]^y[3]=0, else 000.
- Counters: x, y, line and byte counters are sized for their parameter maximums; x and y never exceed their active ranges.
- Frame length at defaults: 150 lines * 464 = 69600 PCLKs = 278400 clks.

Test Plan:
- Release rst with en=0 for 1000 clks -> CAM_pclk toggles with period 4 clks; href, vsync and data stay 0; busy=0.
- en=1, mode=0, solid_color=12'hA5C -> vsync high for 1392 PCLKs. The first active line gives 160 pairs 0x0A,0x5C. HREF high for 320 PCLKs and low for 144 per line, 120 lines. frame_done after 69600 PCLKs; frame_cnt=1.
- mode=1 -> line 0 bytes: pixel 0 = 0x0F,0xFF; pixel 20 = 0x0F,0xF0; pixel 159 = 0x00,0x00. A cam_read instance writes identical words to addresses 0..19199.
- mode changed to 3 mid-frame -> current frame keeps mode 1 throughout; the next frame is checkerboard, with pixel (8,0) = 000 and pixel (8,8) = solid_color.
- en dropped during ACTIVE line 50 -> frame completes, one frame_done pulse, then IDLE with busy=0. Asserting rst low mid-line -> all outputs 0 immediately without waiting for a clk edge.
- Data stability: at every CAM_pclk rising edge, href, vsync and data have not changed in the preceding PCLK_DIV clks. Also run with PCLK_DIV=1.

Source files
------------

// File: rtl/cam_stream_gen.sv
// OV7670-style camera transmitter: divided PCLK plus HREF/VSYNC/8-bit RGB444 pixel bus
// driven from an internal test-pattern engine, one whole frame at a time.
module cam_stream_gen #(
  parameter int H_ACTIVE    = 160,
  parameter int V_ACTIVE    = 120,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int PCLK_DIV    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [11:0] solid_color,
  output logic        CAM_pclk,
  output logic        CAM_href,
  output logic        CAM_vsync,
  output logic [7:0]  CAM_px_data,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
  localparam int HW    = $clog2(LINE);
  localparam int LW    = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT);
  localparam int DW    = $clog2(2 * PCLK_DIV);
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  localparam logic [DW-1:0] DIV_LAST    = DW'(2 * PCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF    = DW'(PCLK_DIV);
  localparam logic [HW-1:0] H_LAST      = HW'(LINE - 1);
  localparam logic [HW-1:0] H_ACT_BYTES = HW'(2 * H_ACTIVE);
  localparam logic [LW-1:0] VS_LAST     = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] VB_LAST     = LW'(V_BACK - 1);
  localparam logic [LW-1:0] VA_LAST     = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] VF_LAST     = LW'(V_FRONT - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t      state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic        pclk_q, pclk_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [11:0] color_q, color_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        frame_done_q, frame_done_d;
  logic        href_q, href_d;
  logic        vsync_q, vsync_d;
  logic [7:0]  data_q, data_d;
  logic        tick;
  logic        start_frame;
  logic [LW-1:0] phase_last;
  logic [15:0] x, y, bar;
  logic [11:0] bar_color, pix;

  // Tick is the clk on which PCLK falls; all bus outputs are re-registered there.
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pclk_d = (div_d >= DIV_HALF);
    tick   = (div_q == DIV_LAST);
  end

  always_comb begin
    case (state_q)
      VSYNC:   phase_last = VS_LAST;
      VBACK:   phase_last = VB_LAST;
      ACTIVE:  phase_last = VA_LAST;
      default: phase_last = VF_LAST;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    lcnt_d       = lcnt_q;
    mode_d       = mode_q;
    color_d      = color_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    start_frame  = 1'b0;
    if (tick) begin
      if (state_q == IDLE) begin
        start_frame = en;
      end else if (hcnt_q != H_LAST) begin
        hcnt_d = hcnt_q + 1'b1;
      end else begin
        hcnt_d = '0;
        if (lcnt_q != phase_last) begin
          lcnt_d = lcnt_q + 1'b1;
        end else begin
          lcnt_d = '0;
          case (state_q)
            VSYNC:  state_d = VBACK;
            VBACK:  state_d = ACTIVE;
            ACTIVE: state_d = VFRONT;
            default: begin
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 16'd1;
              state_d      = IDLE;
              start_frame  = en;
            end
          endcase
        end
      end
      // Pattern settings are captured only at frame start so a frame never mixes modes.
      if (start_frame) begin
        state_d = VSYNC;
        mode_d  = mode;
        color_d = solid_color;
      end
    end
  end

  // Outputs are derived from the position about to be presented on the bus.
  always_comb begin
    x   = 16'(hcnt_d[HW-1:1]);
    y   = 16'(lcnt_d);
    bar = x / 16'(BAR_W);
    case (bar)
      16'd0:   bar_color = 12'hFFF;
      16'd1:   bar_color = 12'hFF0;
      16'd2:   bar_color = 12'h0FF;
      16'd3:   bar_color = 12'h0F0;
      16'd4:   bar_color = 12'hF0F;
      16'd5:   bar_color = 12'hF00;
      16'd6:   bar_color = 12'h00F;
      default: bar_color = 12'h000;
    endcase
    case (mode_d)
      2'd0:    pix = color_d;
      2'd1:    pix = bar_color;
      2'd2:    pix = {4'(x >> 4), 4'(y >> 3), frame_cnt_q[3:0]};
      default: pix = (((x ^ y) & 16'h0008) != 16'h0000) ? 12'h000 : color_d;
    endcase
    href_d  = (state_d == ACTIVE) && (hcnt_d < H_ACT_BYTES);
    vsync_d = (state_d == VSYNC);
    data_d  = 8'h00;
    if (href_d) data_d = hcnt_d[0] ? pix[7:0] : {4'h0, pix[11:8]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      pclk_q       <= 1'b0;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      mode_q       <= 2'd0;
      color_q      <= 12'h000;
      frame_cnt_q  <= 16'h0000;
      frame_done_q <= 1'b0;
      href_q       <= 1'b0;
      vsync_q      <= 1'b0;
      data_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      pclk_q       <= pclk_d;
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      mode_q       <= mode_d;
      color_q      <= color_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      href_q       <= href_d;
      vsync_q      <= vsync_d;
      data_q       <= data_d;
    end
  end

  assign CAM_pclk    = pclk_q;
  assign CAM_href    = href_q;
  assign CAM_vsync   = vsync_q;
  assign CAM_px_data = data_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Scoreboard bench for cam_stream_gen with a shrunken frame; a second instance
// runs with a divide-by-one pixel clock and is checked for bus timing only.
module tb_cam_stream_gen;

  localparam int H_ACTIVE    = 32;
  localparam int V_ACTIVE    = 12;
  localparam int H_BLANK     = 8;
  localparam int VSYNC_LINES = 2;
  localparam int V_BACK      = 2;
  localparam int V_FRONT     = 2;
  localparam int DIV0        = 2;
  localparam int DIV1        = 1;
  localparam int LINE        = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME_PCLK  = LINE * (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT);

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [11:0] solidColor;
  logic        CAM_pclk, CAM_href, CAM_vsync, busy, frameDone;
  logic [7:0]  CAM_px_data;
  logic [15:0] frameCnt;

  logic        en1 = 1'b1;
  logic [1:0]  mode1 = 2'd1;
  logic [11:0] solidColor1 = 12'h123;
  logic        CAM_pclk1, CAM_href1, CAM_vsync1, busy1, frameDone1;
  logic [7:0]  CAM_px_data1;
  logic [15:0] frameCnt1;

  int vectors = 0;
  int miscompares = 0;
  int clkCount = 0;
  logic [7:0] expQ[$];

  cam_stream_gen #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT), .PCLK_DIV(DIV0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_color(solidColor),
    .CAM_pclk(CAM_pclk), .CAM_href(CAM_href), .CAM_vsync(CAM_vsync),
    .CAM_px_data(CAM_px_data), .busy(busy), .frame_done(frameDone), .frame_cnt(frameCnt)
  );

  cam_stream_gen #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT), .PCLK_DIV(DIV1)
  ) dutFast (
    .clk(clk), .rst(rst), .en(en1), .mode(mode1), .solid_color(solidColor1),
    .CAM_pclk(CAM_pclk1), .CAM_href(CAM_href1), .CAM_vsync(CAM_vsync1),
    .CAM_px_data(CAM_px_data1), .busy(busy1), .frame_done(frameDone1), .frame_cnt(frameCnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) clkCount++;

  // Single point through which every comparison is counted and reported.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [11:0] barColor(input int bar);
    case (bar)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] modelPixel(input logic [1:0] m, input logic [11:0] c,
                                            input int x, input int y, input int fc);
    logic [11:0] r;
    case (m)
      2'd0: r = c;
      2'd1: r = barColor(x / (H_ACTIVE / 8));
      2'd2: begin
        r[11:8] = 4'((x >> 4) & 15);
        r[7:4]  = 4'((y >> 3) & 15);
        r[3:0]  = 4'(fc & 15);
      end
      default: r = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 12'h000 : c;
    endcase
    return r;
  endfunction

  task automatic pushFrame(input logic [1:0] m, input logic [11:0] c, input int fc);
    logic [11:0] p;
    for (int y = 0; y < V_ACTIVE; y++) begin
      for (int x = 0; x < H_ACTIVE; x++) begin
        p = modelPixel(m, c, x, y, fc);
        expQ.push_back({4'h0, p[11:8]});
        expQ.push_back(p[7:0]);
      end
    end
  endtask

  // Drives the pattern inputs and, when a frame will be generated from them, queues its bytes.
  task automatic applyStimulus(input logic enV, input logic [1:0] mV, input logic [11:0] cV,
                               input bit pushIt, input int fc);
    @(posedge clk);
    #2;
    en = enV;
    mode = mV;
    solidColor = cV;
    if (pushIt) pushFrame(mV, cV, fc);
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDone(input int maxClks);
    int n = 0;
    while (!frameDone && n < maxClks) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_done_seen", 32'(frameDone), 1);
    @(negedge clk);
  endtask

  task automatic waitHref(input int maxClks);
    int n = 0;
    while (!CAM_href && n < maxClks) begin
      @(negedge clk);
      n++;
    end
    checkOutput("href_seen", 32'(CAM_href), 1);
  endtask

  int sinceChange0, lastRise0, pclkIdx0, hrefRun0, vsRun0, hrefLines0, vsRiseClk0, lastHrefRise0;
  int stabErr0 = 0, periodErr0 = 0, blankErr0 = 0, doneCount0 = 0;
  logic prevPclk0, prevDone0, prevVs0, prevHrefR0, prevVsR0;
  logic [9:0] lastOut0;
  logic [7:0] expByte;

  // Receiver-side monitor for the main instance: samples at each rising PCLK,
  // pops the scoreboard for every HREF byte and checks line/frame timing.
  always @(negedge clk) begin
    if (!rst) begin
      sinceChange0 = 0; lastRise0 = -1; pclkIdx0 = 0; hrefRun0 = 0; vsRun0 = 0;
      hrefLines0 = 0; vsRiseClk0 = -1; lastHrefRise0 = -1;
      prevPclk0 = 1'b0; prevDone0 = 1'b0; prevVs0 = 1'b0; prevHrefR0 = 1'b0; prevVsR0 = 1'b0;
      lastOut0 = '0;
    end else begin
      if ({CAM_href, CAM_vsync, CAM_px_data} != lastOut0) sinceChange0 = 0;
      else sinceChange0++;
      lastOut0 = {CAM_href, CAM_vsync, CAM_px_data};
      if (frameDone) begin
        doneCount0++;
        checkOutput("done_width", 32'(prevDone0), 0);
        if (vsRiseClk0 >= 0) checkOutput("frame_len_clks", clkCount - vsRiseClk0, FRAME_PCLK * 2 * DIV0);
        checkOutput("frame_lines", hrefLines0, V_ACTIVE);
      end
      if (CAM_vsync && !prevVs0) begin
        vsRiseClk0 = clkCount;
        hrefLines0 = 0;
      end
      if (CAM_pclk && !prevPclk0) begin
        if (lastRise0 >= 0 && clkCount - lastRise0 != 2 * DIV0) periodErr0++;
        lastRise0 = clkCount;
        if (sinceChange0 < DIV0) stabErr0++;
        if (CAM_href) begin
          if (!prevHrefR0) begin
            hrefLines0++;
            if (lastHrefRise0 >= 0 && pclkIdx0 - lastHrefRise0 < 2 * LINE)
              checkOutput("line_period", pclkIdx0 - lastHrefRise0, LINE);
            lastHrefRise0 = pclkIdx0;
            hrefRun0 = 0;
          end
          hrefRun0++;
          checkOutput("sb_nonempty", 32'(expQ.size() != 0), 1);
          if (expQ.size() != 0) begin
            expByte = expQ.pop_front();
            checkOutput("px_byte", 32'(CAM_px_data), 32'(expByte));
          end
        end else begin
          if (prevHrefR0) checkOutput("href_high_pclks", hrefRun0, 2 * H_ACTIVE);
          if (CAM_px_data != 8'h00) blankErr0++;
        end
        if (CAM_vsync) vsRun0++;
        else if (prevVsR0) begin
          checkOutput("vsync_high_pclks", vsRun0, VSYNC_LINES * LINE);
          vsRun0 = 0;
        end
        prevHrefR0 = CAM_href;
        prevVsR0 = CAM_vsync;
        pclkIdx0++;
      end
      prevPclk0 = CAM_pclk;
      prevDone0 = frameDone;
      prevVs0 = CAM_vsync;
    end
  end

  int sinceChange1, lastRise1, lastDone1;
  int stabErr1 = 0, periodErr1 = 0, doneCount1 = 0;
  logic prevPclk1;
  logic [9:0] lastOut1;

  // Timing-only monitor for the divide-by-one instance.
  always @(negedge clk) begin
    if (!rst) begin
      sinceChange1 = 0; lastRise1 = -1; lastDone1 = -1;
      prevPclk1 = 1'b0; lastOut1 = '0;
    end else begin
      if ({CAM_href1, CAM_vsync1, CAM_px_data1} != lastOut1) sinceChange1 = 0;
      else sinceChange1++;
      lastOut1 = {CAM_href1, CAM_vsync1, CAM_px_data1};
      if (CAM_pclk1 && !prevPclk1) begin
        if (lastRise1 >= 0 && clkCount - lastRise1 != 2 * DIV1) periodErr1++;
        lastRise1 = clkCount;
        if (sinceChange1 < DIV1) stabErr1++;
      end
      if (frameDone1) begin
        doneCount1++;
        if (lastDone1 >= 0) checkOutput("fast_frame_len_clks", clkCount - lastDone1, FRAME_PCLK * 2 * DIV1);
        lastDone1 = clkCount;
      end
      prevPclk1 = CAM_pclk1;
    end
  end

  int rises, idleErr;
  logic p;

  initial begin
    rst = 1'b0;
    en = 1'b0;
    mode = 2'd0;
    solidColor = 12'h000;
    #13;
    checkOutput("reset_outputs", 32'({CAM_pclk, CAM_href, CAM_vsync, CAM_px_data, busy, frameDone, frameCnt}), 0);
    checkOutput("fast_reset_outputs", 32'({CAM_pclk1, CAM_href1, CAM_vsync1, CAM_px_data1, busy1, frameDone1, frameCnt1}), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;

    rises = 0;
    idleErr = 0;
    p = CAM_pclk;
    repeat (1000) begin
      @(negedge clk);
      if (CAM_pclk && !p) rises++;
      p = CAM_pclk;
      if ({CAM_href, CAM_vsync, CAM_px_data, busy, frameDone, frameCnt} != '0) idleErr++;
    end
    checkOutput("pclk_rises_1000clk", rises, 250);
    checkOutput("idle_quiet", idleErr, 0);

    applyStimulus(1'b1, 2'd0, 12'hA5C, 1'b1, 0);
    waitClks(2000);
    checkOutput("busy_in_frame", 32'(busy), 1);
    applyStimulus(1'b1, 2'd1, 12'hA5C, 1'b1, 1);
    waitDone(8000);
    checkOutput("frame_cnt_1", 32'(frameCnt), 1);

    waitClks(2000);
    applyStimulus(1'b1, 2'd3, 12'h3C7, 1'b1, 2);
    waitDone(8000);
    checkOutput("frame_cnt_2", 32'(frameCnt), 2);

    waitClks(2000);
    applyStimulus(1'b1, 2'd2, 12'h3C7, 1'b1, 3);
    waitDone(8000);
    checkOutput("frame_cnt_3", 32'(frameCnt), 3);

    waitClks(2500);
    checkOutput("href_line_active_before_drop", 32'(busy), 1);
    applyStimulus(1'b0, 2'd2, 12'h3C7, 1'b0, 0);
    waitDone(8000);
    checkOutput("frame_cnt_4", 32'(frameCnt), 4);
    waitClks(20);
    checkOutput("busy_after_drop", 32'(busy), 0);
    waitClks(2000);
    checkOutput("vsync_idle", 32'(CAM_vsync), 0);
    checkOutput("frame_done_pulses", doneCount0, 4);
    checkOutput("sb_drained", expQ.size(), 0);

    applyStimulus(1'b1, 2'd0, 12'hFFF, 1'b1, 4);
    waitHref(4000);
    waitClks(7);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_mid_line", 32'({CAM_pclk, CAM_href, CAM_vsync, CAM_px_data, busy, frameDone, frameCnt}), 0);
    expQ.delete();
    en = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    waitClks(100);
    checkOutput("post_reset_busy", 32'(busy), 0);
    checkOutput("post_reset_frame_cnt", 32'(frameCnt), 0);

    checkOutput("stable_at_pclk_rise", stabErr0, 0);
    checkOutput("pclk_period", periodErr0, 0);
    checkOutput("blank_data_zero", blankErr0, 0);
    checkOutput("fast_stable_at_pclk_rise", stabErr1, 0);
    checkOutput("fast_pclk_period", periodErr1, 0);
    checkOutput("fast_frames_seen", 32'(doneCount1 >= 3), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
